// File: rtl/region_pkg.sv
// Shared types and width helpers for the region statistics engine.
package region_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Area is exact for a full 2^cw x 2^cw window.
    function automatic int unsigned area_w(input int unsigned cw);
        return 2 * cw + 1;
    endfunction

    // Coordinate sums are exact for a full 2^cw x 2^cw window.
    function automatic int unsigned sum_w(input int unsigned cw);
        return 3 * cw + 1;
    endfunction

endpackage

// File: rtl/region_scanner.sv
// Raster-order coordinate walker over a latched inclusive window.
module region_scanner #(
    parameter int unsigned COORD_W = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic               advance_i,
    input  logic [COORD_W-1:0] x0_i,
    input  logic [COORD_W-1:0] y0_i,
    input  logic [COORD_W-1:0] x1_i,
    input  logic [COORD_W-1:0] y1_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               last_o
);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [COORD_W-1:0] wx0_q, wx0_d;
    logic [COORD_W-1:0] wx1_q, wx1_d;
    logic [COORD_W-1:0] wy1_q, wy1_d;
    logic               last_q, last_d;

    // The end test is an equality compare, so x1/y1 at the top of the range never wrap.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        wx0_d  = wx0_q;
        wx1_d  = wx1_q;
        wy1_d  = wy1_q;
        last_d = last_q;
        if (load_i) begin
            x_d    = x0_i;
            y_d    = y0_i;
            wx0_d  = x0_i;
            wx1_d  = x1_i;
            wy1_d  = y1_i;
            last_d = (x0_i == x1_i) && (y0_i == y1_i);
        end else if (advance_i) begin
            if (x_q == wx1_q) begin
                x_d = wx0_q;
                y_d = y_q + COORD_W'(1);
            end else begin
                x_d = x_q + COORD_W'(1);
            end
            last_d = (x_d == wx1_q) && (y_d == wy1_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q    <= '0;
            y_q    <= '0;
            wx0_q  <= '0;
            wx1_q  <= '0;
            wy1_q  <= '0;
            last_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            wx0_q  <= wx0_d;
            wx1_q  <= wx1_d;
            wy1_q  <= wy1_d;
            last_q <= last_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = last_q;

endmodule

// File: rtl/region_stats_engine.sv
// Scans a window of the binary image through the pixel cache and reports
// matched area, coordinate sums and the tight bounding box.
module region_stats_engine
    import region_pkg::*;
#(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned AREA_W  = area_w(COORD_W),
    parameter int unsigned SUM_W   = sum_w(COORD_W)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic               polarity,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               busy,
    output logic               done,
    output logic [AREA_W-1:0]  area,
    output logic [SUM_W-1:0]   sum_x,
    output logic [SUM_W-1:0]   sum_y,
    output logic [COORD_W-1:0] bb_x0,
    output logic [COORD_W-1:0] bb_y0,
    output logic [COORD_W-1:0] bb_x1,
    output logic [COORD_W-1:0] bb_y1,
    output logic               bb_valid,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    input  logic               pixel,
    input  logic               ready
);

    state_e             state_q, state_d;
    logic               pol_q, pol_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [AREA_W-1:0]  area_q, area_d;
    logic [SUM_W-1:0]   sumx_q, sumx_d;
    logic [SUM_W-1:0]   sumy_q, sumy_d;
    logic [COORD_W-1:0] bbx0_q, bbx0_d;
    logic [COORD_W-1:0] bby0_q, bby0_d;
    logic [COORD_W-1:0] bbx1_q, bbx1_d;
    logic [COORD_W-1:0] bby1_q, bby1_d;
    logic               bbv_q, bbv_d;

    logic               accept_c;
    logic               hit_c;
    logic               advance_c;
    logic [COORD_W-1:0] x_w, y_w;
    logic               last_w;

    region_scanner #(
        .COORD_W (COORD_W)
    ) u_scanner (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (accept_c),
        .advance_i (advance_c),
        .x0_i      (x0),
        .y0_i      (y0),
        .x1_i      (x1),
        .y1_i      (y1),
        .x_o       (x_w),
        .y_o       (y_w),
        .last_o    (last_w)
    );

    // Next-state and result update; abort dominates everything else.
    always_comb begin
        state_d  = state_q;
        pol_d    = pol_q;
        area_d   = area_q;
        sumx_d   = sumx_q;
        sumy_d   = sumy_q;
        bbx0_d   = bbx0_q;
        bby0_d   = bby0_q;
        bbx1_d   = bbx1_q;
        bby1_d   = bby1_q;
        bbv_d    = bbv_q;

        accept_c  = start && !abort && ((state_q == IDLE) || (state_q == DONE));
        hit_c     = !abort && (state_q == SAMPLE) && ready;
        advance_c = hit_c && !last_w;

        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (accept_c) begin
                        state_d = ((x1 < x0) || (y1 < y0)) ? DONE : ISSUE;
                    end
                end
                // ready is not trusted here: it may still describe the previous address.
                ISSUE:   state_d = SAMPLE;
                SAMPLE: begin
                    if (ready) begin
                        state_d = last_w ? DONE : ISSUE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (abort || accept_c) begin
            area_d = '0;
            sumx_d = '0;
            sumy_d = '0;
            bbx0_d = '0;
            bby0_d = '0;
            bbx1_d = '0;
            bby1_d = '0;
            bbv_d  = 1'b0;
            if (accept_c) begin
                pol_d = polarity;
            end
        end else if (hit_c && (pixel == pol_q)) begin
            area_d = area_q + AREA_W'(1);
            sumx_d = sumx_q + SUM_W'(x_w);
            sumy_d = sumy_q + SUM_W'(y_w);
            bbv_d  = 1'b1;
            if (!bbv_q) begin
                bbx0_d = x_w;
                bby0_d = y_w;
                bbx1_d = x_w;
                bby1_d = y_w;
            end else begin
                if (x_w < bbx0_q) bbx0_d = x_w;
                if (y_w < bby0_q) bby0_d = y_w;
                if (x_w > bbx1_q) bbx1_d = x_w;
                if (y_w > bby1_q) bby1_d = y_w;
            end
        end

        busy_d = (state_d == ISSUE) || (state_d == SAMPLE);
        // done trails entry into DONE by one edge, once the last result has landed.
        done_d = (state_q == DONE) && !abort && !accept_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pol_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            area_q  <= '0;
            sumx_q  <= '0;
            sumy_q  <= '0;
            bbx0_q  <= '0;
            bby0_q  <= '0;
            bbx1_q  <= '0;
            bby1_q  <= '0;
            bbv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pol_q   <= pol_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            area_q  <= area_d;
            sumx_q  <= sumx_d;
            sumy_q  <= sumy_d;
            bbx0_q  <= bbx0_d;
            bby0_q  <= bby0_d;
            bbx1_q  <= bbx1_d;
            bby1_q  <= bby1_d;
            bbv_q   <= bbv_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign area     = area_q;
    assign sum_x    = sumx_q;
    assign sum_y    = sumy_q;
    assign bb_x0    = bbx0_q;
    assign bb_y0    = bby0_q;
    assign bb_x1    = bbx1_q;
    assign bb_y1    = bby1_q;
    assign bb_valid = bbv_q;
    assign x        = x_w;
    assign y        = y_w;

endmodule

// File: tb/tb_region_stats_engine.sv
// Directed bench for region_stats_engine with a small four-pixel image model.
module tb_region_stats_engine;

    localparam int unsigned CW = 10;
    localparam int unsigned AW = 21;
    localparam int unsigned SW = 31;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          polarity = 1'b1;
    logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic          busy, done, bb_valid;
    logic [AW-1:0] area;
    logic [SW-1:0] sum_x, sum_y;
    logic [CW-1:0] bb_x0, bb_y0, bb_x1, bb_y1, x, y;
    logic          pixel, ready;

    logic          auto_mode = 1'b1;
    logic          man_ready = 1'b0;
    logic          man_pixel = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    bit busy_seen;

    always #5 clk = ~clk;

    function automatic logic img(input logic [CW-1:0] px, input logic [CW-1:0] py);
        return ((px == 7) && (py == 2)) || ((px == 3) && (py == 3)) ||
               ((px == 9) && (py == 4)) || ((px == 5) && (py == 5));
    endfunction

    assign ready = auto_mode ? 1'b1 : man_ready;
    assign pixel = auto_mode ? img(x, y) : man_pixel;

    region_stats_engine #(.COORD_W(CW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .polarity (polarity),
        .x0       (x0),
        .y0       (y0),
        .x1       (x1),
        .y1       (y1),
        .busy     (busy),
        .done     (done),
        .area     (area),
        .sum_x    (sum_x),
        .sum_y    (sum_y),
        .bb_x0    (bb_x0),
        .bb_y0    (bb_y0),
        .bb_x1    (bb_x1),
        .bb_y1    (bb_y1),
        .bb_valid (bb_valid),
        .x        (x),
        .y        (y),
        .pixel    (pixel),
        .ready    (ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_win(input logic pol, input int ax0, input int ay0, input int ax1, input int ay1);
        polarity = pol;
        x0 = CW'(ax0);
        y0 = CW'(ay0);
        x1 = CW'(ax1);
        y1 = CW'(ay1);
    endtask

    // Pulses start, then counts edges until done; optionally re-pulses start mid-scan.
    task automatic run_scan(input int inj_at, output int ncyc, output bit bseen);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ncyc  = 0;
        bseen = busy;
        while (!done && ncyc < 3000) begin
            @(posedge clk);
            #1;
            ncyc++;
            start = 1'b0;
            if (busy) bseen = 1'b1;
            if (ncyc == inj_at) begin
                start    = 1'b1;
                x1       = '0;
                polarity = ~polarity;
            end
        end
        check_eq("scan_done_in_budget", 64'(done), 64'd1);
    endtask

    task automatic check_results(input string tag, input int ea, input int esx, input int esy,
                                 input int bx0, input int by0, input int bx1, input int by1,
                                 input int ev);
        check_eq({tag, "_area"},  64'(area),     64'(ea));
        check_eq({tag, "_sumx"},  64'(sum_x),    64'(esx));
        check_eq({tag, "_sumy"},  64'(sum_y),    64'(esy));
        check_eq({tag, "_bbx0"},  64'(bb_x0),    64'(bx0));
        check_eq({tag, "_bby0"},  64'(bb_y0),    64'(by0));
        check_eq({tag, "_bbx1"},  64'(bb_x1),    64'(bx1));
        check_eq({tag, "_bby1"},  64'(bb_y1),    64'(by1));
        check_eq({tag, "_bbv"},   64'(bb_valid), 64'(ev));
    endtask

    initial begin
        // Reset state
        #12;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_x",    64'(x),    64'd0);
        check_eq("rst_y",    64'(y),    64'd0);
        check_results("rst", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Full window, polarity 1
        set_win(1'b1, 0, 0, 9, 9);
        run_scan(-1, cyc, busy_seen);
        check_eq("full_p1_cycles", 64'(cyc), 64'd201);
        check_eq("full_p1_busy_seen", 64'(busy_seen), 64'd1);
        check_eq("full_p1_busy_at_done", 64'(busy), 64'd0);
        check_results("full_p1", 4, 24, 14, 3, 2, 9, 5, 1);
        check_eq("full_p1_last_x", 64'(x), 64'd9);
        check_eq("full_p1_last_y", 64'(y), 64'd9);

        // Right part of the window, restarted from DONE
        set_win(1'b1, 4, 0, 9, 9);
        run_scan(-1, cyc, busy_seen);
        check_eq("right_cycles", 64'(cyc), 64'd121);
        check_results("right", 3, 21, 11, 5, 2, 9, 5, 1);

        // Polarity 0 over the full window
        set_win(1'b0, 0, 0, 9, 9);
        run_scan(-1, cyc, busy_seen);
        check_results("full_p0", 96, 426, 436, 0, 0, 9, 9, 1);

        // Inverted window: straight to DONE
        set_win(1'b1, 5, 0, 4, 9);
        run_scan(-1, cyc, busy_seen);
        check_eq("inv_cycles", 64'(cyc), 64'd1);
        check_eq("inv_busy_seen", 64'(busy_seen), 64'd0);
        check_results("inv", 0, 0, 0, 0, 0, 0, 0, 0);

        // Start while busy (with changed window/polarity) is ignored
        set_win(1'b1, 0, 0, 9, 9);
        run_scan(50, cyc, busy_seen);
        check_eq("ign_start_cycles", 64'(cyc), 64'd201);
        check_results("ign_start", 4, 24, 14, 3, 2, 9, 5, 1);

        // Single pixel with cache stalls and a stale ready during ISSUE
        auto_mode = 1'b0;
        for (int r = 0; r < 3; r++) begin
            int k;
            k = (r == 0) ? 0 : int'($urandom_range(0, 5));
            set_win(1'b1, 9, 4, 9, 4);
            @(negedge clk);
            man_ready = 1'b1;
            man_pixel = 1'b1;
            start     = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            check_eq("stall_busy_issue", 64'(busy), 64'd1);
            @(posedge clk);
            #1;
            man_ready = 1'b0;
            man_pixel = 1'b0;
            for (int i = 0; i < k; i++) begin
                @(posedge clk);
                #1;
                check_eq("stall_x_stable", 64'(x), 64'd9);
                check_eq("stall_y_stable", 64'(y), 64'd4);
                check_eq("stall_busy", 64'(busy), 64'd1);
            end
            man_ready = 1'b1;
            man_pixel = 1'b1;
            for (int i = 0; i < 10 && !done; i++) begin
                @(posedge clk);
                #1;
            end
            check_eq("stall_done", 64'(done), 64'd1);
            check_results("stall", 1, 9, 4, 9, 4, 9, 4, 1);
        end
        auto_mode = 1'b1;

        // Abort mid-scan, asserted together with start
        set_win(1'b0, 0, 0, 9, 9);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_eq("pre_abort_busy", 64'(busy), 64'd1);
        check_eq("pre_abort_area", 64'(area), 64'd20);
        check_eq("pre_abort_x", 64'(x), 64'd0);
        check_eq("pre_abort_y", 64'(y), 64'd2);
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_results("abort", 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_eq("abort_idle_busy", 64'(busy), 64'd0);
        check_eq("abort_idle_done", 64'(done), 64'd0);

        // Asynchronous reset mid-scan
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_eq("pre_rst_area", 64'(area), 64'd20);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_x", 64'(x), 64'd0);
        check_eq("arst_y", 64'(y), 64'd0);
        check_results("arst", 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("post_rst_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/region_stats_engine.md
Name: region_stats_engine

Overview:
- Parametrised successor to the single-region area counter.
- Scans a rectangular window of the binary image through the pixel cache.
- Per window it reports:
  - matched-pixel area;
  - X and Y coordinate sums, from which downstream logic derives the centroid;
  - tight bounding box of the matched pixels.
- Adds a proper start/busy/done FSM, abort, a selectable match polarity, empty/inverted-window handling, and a stale-ready guard.

Parameters:
- COORD_W, 10: width of every x/y coordinate.
- AREA_W, 2*COORD_W+1: area counter width; exact for a full 2^COORD_W square window.
- SUM_W, 3*COORD_W+1: width of sum_x and sum_y; exact, never overflows.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- abort  in  1  cancels any scan.
- polarity  in  1  pixel value that counts as a match; latched at start.
- x0, y0, x1, y1  in  COORD_W each  inclusive window corners; latched at start.
- busy  out  1  high in ISSUE or SAMPLE.
- done  out  1  level, high in DONE until the next accepted start or abort.
- area  out  AREA_W  matched-pixel count.
- sum_x, sum_y  out  SUM_W each  sums of matched-pixel coordinates.
- bb_x0, bb_y0, bb_x1, bb_y1  out  COORD_W each  tight bounding box of matches.
- bb_valid  out  1  high when area > 0.
- x, y  out  COORD_W each  pixel-cache read address.
- pixel  in  1  cache data; valid only with ready.
- ready  in  1  cache has the pixel at the current x, y.

Behaviour:
- Reset (reset_n low, async): state IDLE; every output 0, including x, y and the bb_* outputs.
- States: IDLE, ISSUE, SAMPLE, DONE.
- IDLE/DONE + start (accepted):
  - latch window and polarity;
  - x<=x0, y<=y0;
  - clear area, sums, bb_valid; done<=0;
  - if x1<x0 or y1<y0, go directly to DONE with all results 0;
  - otherwise go to ISSUE.
- ISSUE:
  - lasts exactly one cycle;
  - ready is ignored here, because it may be stale from the previous address;
  - go to SAMPLE.
- SAMPLE:
  - x, y held stable; wait any number of cycles for ready.
  - On ready with pixel==polarity:
    - area+1; sum_x+=x; sum_y+=y;
    - bb update: min/max against current bb, or load x, y, x, y when bb_valid is 0;
    - bb_valid<=1.
  - On ready at the last pixel (x==x1 && y==y1): go to DONE. The final pixel is included.
  - On ready at any other pixel:
    - if x==x1 then x<=x0, y<=y+1, else x<=x+1;
    - go to ISSUE.
- DONE:
  - done=1, busy=0; results held stable;
  - x, y hold the last address.
- abort, any state:
  - next state IDLE; done, busy, area, sums and bb_* all cleared.
  - abort wins over a simultaneous start.
  - abort has no effect when already in IDLE with cleared outputs.
- start while busy: ignored, no effect.
- Timing, assuming ready is always high:
  - an N-pixel window needs 2N cycles of scanning;
  - done rises on the (2N+1)th rising edge after the edge that sampled start.
- Coordinate arithmetic:
  - no wrap beyond x1/y1;
  - x1 = 2^COORD_W-1 is legal; the end test compares equality, never x+1.
- All additions are unsigned and zero-extended to the destination width.

Decomposition:
- Package region_pkg:
  - state enum: IDLE, ISSUE, SAMPLE, DONE;
  - helper functions deriving AREA_W and SUM_W from COORD_W.
- Sub-module region_scanner: the coordinate walker.
  - Inputs: load, advance, window.
  - Outputs: x, y, last.
  - The FSM and accumulators stay in region_stats_engine.

Test Plan:
- Window (0,0)-(9,9), polarity 1, set pixels at (7,2), (3,3), (9,4), (5,5), cache always ready:
  - area=4, sum_x=24, sum_y=14, bb=(3,2)-(9,5), bb_valid=1;
  - done rises 201 cycles after the start edge.
- Same image, window (4,0)-(9,9):
  - area=3, sum_x=21, sum_y=11, bb=(5,2)-(9,5).
- Same image, polarity 0, window (0,0)-(9,9):
  - area=96, sum_x=426, sum_y=436, bb=(0,0)-(9,9).
- Inverted window x0=5, x1=4:
  - done on the next edge, busy never high, area=0, bb_valid=0.
- Cache with random ready stalls of 0-5 cycles on window (9,4)-(9,4):
  - area=1, sum_x=9, sum_y=4;
  - x, y stable throughout SAMPLE;
  - a stale ready during ISSUE is not counted.
- Edge cases:
  - abort mid-scan: outputs 0 and state IDLE next cycle;
  - start while busy: ignored;
  - reset_n pulsed low mid-scan: all outputs 0 immediately, without waiting for a clock edge.
